// File: rtl/candy_pkg.sv
// candy_pkg: shared command codes, channel indices and emitter state for the candy vending front end
package candy_pkg;
  localparam logic [2:0] NO_COIN    = 3'b111;
  localparam logic [2:0] BEG        = 3'b001;
  localparam logic [2:0] OBEG       = 3'b010;
  localparam logic [2:0] CANDY_BTN  = 3'b101;
  localparam logic [2:0] CHANGE_BTN = 3'b110;
  typedef enum logic [1:0] {CH_BEG, CH_OBEG, CH_CANDY, CH_CHANGE} ch_e;
  typedef enum logic {IDLE, EMIT} emit_state_e;
  function automatic logic [2:0] pick(input logic [3:0] r);
    return r[CH_CHANGE] ? CHANGE_BTN : r[CH_CANDY] ? CANDY_BTN : r[CH_OBEG] ? OBEG : r[CH_BEG] ? BEG : NO_COIN;
  endfunction
  function automatic logic [3:0] top_bit(input logic [3:0] r);
    return r[CH_CHANGE] ? 4'b1000 : r[CH_CANDY] ? 4'b0100 : r[CH_OBEG] ? 4'b0010 : r[CH_BEG] ? 4'b0001 : 4'b0000;
  endfunction
endpackage

// File: rtl/input_debounce.sv
// input_debounce: 2-FF synchroniser, counter debouncer and rising-edge request for one raw input
// Ports: clk, reset (async, active-high), raw (asynchronous input),
//        req (one-cycle pulse after an accepted 0->1 change), rise (req of the next cycle)
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic req,
  output logic rise
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  logic s1, s, stable, hit;
  logic [W-1:0] cnt;
  assign hit = (s != stable) && (cnt == W'(DEBOUNCE_CYCLES - 1));
  assign rise = hit & s;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      s <= 1'b0;
      stable <= 1'b0;
      cnt <= '0;
      req <= 1'b0;
    end else begin
      s1 <= raw;
      s <= s1;
      req <= rise;
      if (s == stable) cnt <= '0;
      else if (hit) begin
        stable <= s;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/coin_input_encoder.sv
// coin_input_encoder: debounces coin sensors and buttons into single-cycle candy controller command codes
// Ports: clk, reset (async, active-high), coin_beg_raw, coin_obeg_raw, btn_candy_raw, btn_change_raw
//        (raw asynchronous inputs), in_code (3-bit command, 3'b111 idle), dropped (discarded press pulse)
// Option: EVENT_HOLD_EN keeps a pending bit per channel so simultaneous presses are all delivered.
module coin_input_encoder
  import candy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_beg_raw,
  input  logic       coin_obeg_raw,
  input  logic       btn_candy_raw,
  input  logic       btn_change_raw,
  output logic [2:0] in_code,
  output logic       dropped
);
  logic [3:0] raw, req, rise, avail;
  logic [2:0] code_d;
  logic drop_d;
  emit_state_e state, state_d;
  assign raw[CH_BEG] = coin_beg_raw;
  assign raw[CH_OBEG] = coin_obeg_raw;
  assign raw[CH_CANDY] = btn_candy_raw;
  assign raw[CH_CHANGE] = btn_change_raw;
  for (genvar i = 0; i < 4; i++) begin : g_db
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .raw(raw[i]),
      .req(req[i]),
      .rise(rise[i])
    );
  end
`ifdef EVENT_HOLD_EN
  logic [3:0] pend, pend_d;
  assign avail = pend | req;
  // dropped is registered, so it is judged one cycle early against the pending bits the request will meet
  always_comb begin
    pend_d = avail & ~((state == IDLE) ? top_bit(avail) : 4'b0000);
    drop_d = |(rise & pend_d);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) pend <= 4'b0000;
    else pend <= pend_d;
`else
  assign avail = req;
  // a request meeting EMIT, or losing arbitration in IDLE, is discarded; judged one cycle early
  always_comb drop_d = (state_d == EMIT) ? |rise : |(rise & (rise - 4'd1));
`endif
  always_comb begin
    state_d = (state == IDLE && |avail) ? EMIT : IDLE;
    code_d = (state == IDLE) ? pick(avail) : NO_COIN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      in_code <= NO_COIN;
      dropped <= 1'b0;
    end else begin
      state <= state_d;
      in_code <= code_d;
      dropped <= drop_d;
    end
endmodule

// File: tb/tb_coin_input_encoder.sv
// tb_coin_input_encoder: directed self-checking bench for coin_input_encoder
module tb_coin_input_encoder;
  import candy_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_beg_raw = 1'b0, coin_obeg_raw = 1'b0, btn_candy_raw = 1'b0, btn_change_raw = 1'b0;
  logic [2:0] in_code;
  logic dropped;
  int n_chk = 0, n_fail = 0;
  int et [4];
  logic [2:0] ek [4];
  int edrop;

  coin_input_encoder #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .coin_beg_raw(coin_beg_raw),
    .coin_obeg_raw(coin_obeg_raw),
    .btn_candy_raw(btn_candy_raw),
    .btn_change_raw(btn_change_raw),
    .in_code(in_code),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 4; i++) begin
      et[i] = -1;
      ek[i] = NO_COIN;
    end
    edrop = -1;
  endtask

  // cycle c is the cycle following rising edge c after the stimulus change
  task automatic run(input string tag, input int n);
    logic [2:0] e;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      e = NO_COIN;
      for (int i = 0; i < 4; i++) if (et[i] == c) e = ek[i];
      chk($sformatf("%s code c%0d", tag, c), {1'b0, in_code}, {1'b0, e});
      chk($sformatf("%s drop c%0d", tag, c), {3'b0, dropped}, {3'b0, c == edrop});
    end
    clear_ev();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s rst code", tag), {1'b0, in_code}, {1'b0, NO_COIN});
      chk($sformatf("%s rst drop", tag), {3'b0, dropped}, 4'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    clear_ev();
    do_reset("init");
    coin_beg_raw = 1'b1;
    et[0] = 19; ek[0] = BEG;
    run("single", 40);
    coin_beg_raw = 1'b0;
    run("single_tail", 30);
    btn_candy_raw = 1'b1; run("glitch3", 3);
    btn_candy_raw = 1'b0; run("gap", 30);
    btn_candy_raw = 1'b1; run("glitch10", 10);
    btn_candy_raw = 1'b0; run("gap", 30);
    btn_candy_raw = 1'b1; run("glitch15", 15);
    btn_candy_raw = 1'b0; run("gap", 30);
    for (int k = 0; k < 10; k++) begin
      coin_obeg_raw = (k % 2 == 0);
      run("bounce", 2);
    end
    coin_obeg_raw = 1'b1;
    et[0] = 19; ek[0] = OBEG;
    run("bounce_hold", 40);
    coin_obeg_raw = 1'b0;
    run("bounce_tail", 30);
    do_reset("sim");
    {coin_beg_raw, coin_obeg_raw, btn_candy_raw, btn_change_raw} = 4'b1111;
`ifdef EVENT_HOLD_EN
    et[0] = 19; ek[0] = CHANGE_BTN;
    et[1] = 21; ek[1] = CANDY_BTN;
    et[2] = 23; ek[2] = OBEG;
    et[3] = 25; ek[3] = BEG;
`else
    et[0] = 19; ek[0] = CHANGE_BTN;
    edrop = 18;
`endif
    run("simul", 40);
    {coin_beg_raw, coin_obeg_raw, btn_candy_raw, btn_change_raw} = 4'b0000;
    run("simul_tail", 30);
    do_reset("mid");
    btn_change_raw = 1'b1;
    run("mid_pre", 9);
    do_reset("mid_pulse");
    et[0] = 19; ek[0] = CHANGE_BTN;
    run("mid_post", 40);
    btn_change_raw = 1'b0;
    run("mid_tail", 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
